// File: rtl/uart_rx_deframer_if.sv
// Byte output handshake of uart_rx_deframer: the receiver is the master
// (drives data/valid) and the consumer is the slave (drives ready).
interface uart_rx_deframer_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receiver: synchronizes, majority-filters and 16x-oversamples rx_i,
// deframes 8N1 (8E1/8O1 when UART_RX_PARITY_EN is defined) into a one-byte buffer.
module uart_rx_deframer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic             rx_en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             parity_odd_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             parity_err_o,
  input  logic             err_clr_i,
  uart_rx_deframer_if.master out_if
);

  localparam int unsigned SCNT_W = 4;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DIV_W-1:0]       div_q;
  logic [2:0]             filt_q;
  state_e                 state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [BYTE_W-1:0]      shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic                   rx_s_c, rx_f_c, tick_c, hold_c;
  logic                   push_c, frame_set_c, overrun_set_c;

  assign rx_s_c = sync_q[SYNC_STAGES-1];
  assign rx_f_c = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
  assign tick_c = (div_q == '0);
  // Idle line parks the divider at 0, so the filter tracks the line every cycle
  assign hold_c = !rx_en_i || ((state_q == IDLE) && rx_s_c);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      filt_q <= '1;
      div_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      if (tick_c) filt_q <= {filt_q[1:0], rx_s_c};
      if (hold_c)      div_q <= '0;
      else if (tick_c) div_q <= baud_div_i;
      else             div_q <= div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set_c;
`endif

  // Deframer: START checks the start-bit centre at sample 7, later bits at sample 15
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set_c   = 1'b0;
`endif
    if (!rx_en_i) begin
      state_d = IDLE;
      scnt_d  = '0;
      bcnt_d  = '0;
      armed_d = 1'b0;
    end else if (tick_c) begin
      case (state_q)
        IDLE: begin
          if (rx_f_c) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            scnt_d  = '0;
            armed_d = 1'b0;
          end
        end
        START: begin
          if (scnt_q == SCNT_W'(7)) begin
            scnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_f_c ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        DATA: begin
          if (scnt_q == SCNT_W'(15)) begin
            scnt_d  = '0;
            shreg_d = {rx_f_c, shreg_q[BYTE_W-1:1]};
            bcnt_d  = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_W'(7)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (scnt_q == SCNT_W'(15)) begin
            scnt_d    = '0;
            par_set_c = (rx_f_c != ((^shreg_q) ^ parity_odd_i));
            state_d   = STOP;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (scnt_q == SCNT_W'(15)) begin
            scnt_d      = '0;
            push_c      = 1'b1;
            frame_set_c = !rx_f_c;
            state_d     = IDLE;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign overrun_set_c = push_c && out_if.valid && !out_if.ready;

  // One-byte output buffer; a full buffer that is not being drained drops the new byte
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_if.data  <= '0;
      out_if.valid <= 1'b0;
    end else if (push_c && (!out_if.valid || out_if.ready)) begin
      out_if.data  <= shreg_q;
      out_if.valid <= 1'b1;
    end else if (out_if.valid && out_if.ready) begin
      out_if.valid <= 1'b0;
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (frame_set_c)    frame_err_o <= 1'b1;
      else if (err_clr_i) frame_err_o <= 1'b0;
      if (overrun_set_c)  overrun_o   <= 1'b1;
      else if (err_clr_i) overrun_o   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)          parity_err_o <= 1'b0;
    else if (par_set_c) parity_err_o <= 1'b1;
    else if (err_clr_i) parity_err_o <= 1'b0;
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
  assign parity_err_o      = 1'b0;
`endif

endmodule
